// File: rtl/reservation_station_pkg.sv
// Shared types and wakeup tag-compare helpers for the reservation station.
// The opcode and ROB-index widths are fixed here because the entry struct carries them.
package reservation_station_pkg;
  localparam int NUM_WAKEUP = 4;
  localparam int TAG_W      = 6;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 8;
  localparam int ROB_W      = 6;

  typedef logic [NUM_WAKEUP-1:0][TAG_W-1:0]  wake_tags_t;
  typedef logic [NUM_WAKEUP-1:0][DATA_W-1:0] wake_values_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              ready;
    logic [DATA_W-1:0] value;
  } operand_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob_idx;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    operand_t          rs1;
    operand_t          rs2;
  } rs_entry_t;

  // Single tag comparator used for both alloc-time capture and entry snooping.
  // Tag 0 never matches; the loop runs downward so the lowest bus index wins.
  function automatic operand_t operand_capture(input operand_t opnd,
                                               input logic [NUM_WAKEUP-1:0] active,
                                               input wake_tags_t tags,
                                               input wake_values_t values);
    operand_t r;
    r = opnd;
    if (!opnd.ready) begin
      for (int w = NUM_WAKEUP - 1; w >= 0; w--) begin
        if (active[w] && (tags[w] != '0) && (tags[w] == opnd.tag)) begin
          r.ready = 1'b1;
          r.value = values[w];
        end
      end
    end
    return r;
  endfunction

  function automatic logic wakeup_conflict(input logic [NUM_WAKEUP-1:0] active,
                                           input wake_tags_t tags);
    logic c;
    c = 1'b0;
    for (int a = 0; a < NUM_WAKEUP; a++) begin
      for (int b = a + 1; b < NUM_WAKEUP; b++) begin
        if (active[a] && active[b] && (tags[a] != '0) && (tags[a] == tags[b])) c = 1'b1;
      end
    end
    return c;
  endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Rename-side alloc bus, FU wakeup broadcasts and FU-dispatch issue bus.
interface reservation_station_if
  import reservation_station_pkg::*;
  #(parameter int DEPTH = 16) ();

  // Handshakes: a transfer happens on the posedge where valid && ready are both high;
  // ready never depends on valid in the same cycle, and valid holds its payload steady.
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OP_W-1:0]   alloc_op;
  logic [ROB_W-1:0]  alloc_rob_idx;
  logic [TAG_W-1:0]  alloc_rd;
  logic [DATA_W-1:0] alloc_imm;
  logic [TAG_W-1:0]  alloc_rs1_tag;
  logic              alloc_rs1_ready;
  logic [DATA_W-1:0] alloc_rs1_value;
  logic [TAG_W-1:0]  alloc_rs2_tag;
  logic              alloc_rs2_ready;
  logic [DATA_W-1:0] alloc_rs2_value;

  logic [NUM_WAKEUP-1:0] wakeup_active;
  wake_tags_t            wakeup_tag;
  wake_values_t          wakeup_value;

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic [TAG_W-1:0]  issue_rd;
  logic [DATA_W-1:0] issue_imm;
  logic [DATA_W-1:0] issue_rs1_value;
  logic [DATA_W-1:0] issue_rs2_value;

  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output alloc_valid, alloc_op, alloc_rob_idx, alloc_rd, alloc_imm,
           alloc_rs1_tag, alloc_rs1_ready, alloc_rs1_value,
           alloc_rs2_tag, alloc_rs2_ready, alloc_rs2_value,
           wakeup_active, wakeup_tag, wakeup_value, issue_ready,
    input  alloc_ready, issue_valid, issue_op, issue_rob_idx, issue_rd, issue_imm,
           issue_rs1_value, issue_rs2_value, count
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_rob_idx, alloc_rd, alloc_imm,
           alloc_rs1_tag, alloc_rs1_ready, alloc_rs1_value,
           alloc_rs2_tag, alloc_rs2_ready, alloc_rs2_value,
           wakeup_active, wakeup_tag, wakeup_value, issue_ready,
    output alloc_ready, issue_valid, issue_op, issue_rob_idx, issue_rd, issue_imm,
           issue_rs1_value, issue_rs2_value, count
  );
endinterface

// File: rtl/reservation_station_age_select.sv
// Oldest-first picker: grants the eligible entry that no other eligible entry is older than.
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] age,      // age[i][j]: entry i is older than entry j
  input  logic [DEPTH-1:0]            eligible,
  output logic [DEPTH-1:0]            grant
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && eligible[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds renamed instructions until both operands are known,
// snoops the FU wakeup buses, and issues the oldest ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  reservation_station_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t [DEPTH-1:0]       entries;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [CNT_W-1:0]            count_q;
  logic [DEPTH-1:0]            eligible;
  logic [DEPTH-1:0]            grant;
  logic [DEPTH-1:0]            alloc_sel;
  rs_entry_t                   new_entry;
  operand_t                    rs1_in, rs2_in;
  logic                        alloc_fire, issue_fire;

  // Registered count only, so an issue this cycle never frees room for an alloc this cycle.
  assign bus.alloc_ready = (count_q != CNT_W'(DEPTH));
  assign bus.count       = count_q;
  assign bus.issue_valid = |eligible;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign issue_fire      = bus.issue_valid && bus.issue_ready;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++)
      eligible[i] = entries[i].valid && entries[i].rs1.ready && entries[i].rs2.ready;
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .age      (age),
    .eligible (eligible),
    .grant    (grant)
  );

  always_comb begin
    bus.issue_op        = '0;
    bus.issue_rob_idx   = '0;
    bus.issue_rd        = '0;
    bus.issue_imm       = '0;
    bus.issue_rs1_value = '0;
    bus.issue_rs2_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.issue_op        = bus.issue_op        | entries[i].op;
        bus.issue_rob_idx   = bus.issue_rob_idx   | entries[i].rob_idx;
        bus.issue_rd        = bus.issue_rd        | entries[i].rd;
        bus.issue_imm       = bus.issue_imm       | entries[i].imm;
        bus.issue_rs1_value = bus.issue_rs1_value | entries[i].rs1.value;
        bus.issue_rs2_value = bus.issue_rs2_value | entries[i].rs2.value;
      end
    end
  end

  // Lowest free slot; the slot being issued is still valid, so it is never chosen.
  always_comb begin
    alloc_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        alloc_sel    = '0;
        alloc_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rs1_in.tag   = bus.alloc_rs1_tag;
    rs1_in.ready = bus.alloc_rs1_ready;
    rs1_in.value = bus.alloc_rs1_value;
    rs2_in.tag   = bus.alloc_rs2_tag;
    rs2_in.ready = bus.alloc_rs2_ready;
    rs2_in.value = bus.alloc_rs2_value;
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.op      = bus.alloc_op;
    new_entry.rob_idx = bus.alloc_rob_idx;
    new_entry.rd      = bus.alloc_rd;
    new_entry.imm     = bus.alloc_imm;
    new_entry.rs1     = operand_capture(rs1_in, bus.wakeup_active, bus.wakeup_tag, bus.wakeup_value);
    new_entry.rs2     = operand_capture(rs2_in, bus.wakeup_active, bus.wakeup_tag, bus.wakeup_value);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries <= '0;
      age     <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_fire && alloc_sel[i]) begin
          entries[i] <= new_entry;
        end else if (issue_fire && grant[i]) begin
          entries[i].valid <= 1'b0;
        end else if (entries[i].valid) begin
          entries[i].rs1 <= operand_capture(entries[i].rs1, bus.wakeup_active,
                                            bus.wakeup_tag, bus.wakeup_value);
          entries[i].rs2 <= operand_capture(entries[i].rs2, bus.wakeup_active,
                                            bus.wakeup_tag, bus.wakeup_value);
        end
        // New entry is older than nobody; every currently valid entry is older than it.
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_fire && alloc_sel[i])      age[i][j] <= 1'b0;
          else if (alloc_fire && alloc_sel[j]) age[i][j] <= entries[i].valid;
        end
      end
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    end
  end

  a_alloc_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.alloc_valid && !bus.alloc_ready))
    else $fatal(1, "reservation_station: alloc_valid while alloc_ready is low");

  a_wakeup_dup_tag: assert property (@(posedge clk) disable iff (!reset_n)
    !wakeup_conflict(bus.wakeup_active, bus.wakeup_tag))
    else $fatal(1, "reservation_station: two active wakeups carry the same tag");
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an in-order issue scoreboard.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = OP_W + ROB_W + TAG_W + 3 * DATA_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  reservation_station_if #(.DEPTH(DEPTH)) bus ();

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                                        input logic [TAG_W-1:0] rd, input logic [DATA_W-1:0] imm,
                                        input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    return {op, rob, rd, imm, v1, v2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid     = 1'b0;
    bus.alloc_op        = '0;
    bus.alloc_rob_idx   = '0;
    bus.alloc_rd        = '0;
    bus.alloc_imm       = '0;
    bus.alloc_rs1_tag   = '0;
    bus.alloc_rs1_ready = 1'b0;
    bus.alloc_rs1_value = '0;
    bus.alloc_rs2_tag   = '0;
    bus.alloc_rs2_ready = 1'b0;
    bus.alloc_rs2_value = '0;
    bus.wakeup_active   = '0;
    bus.wakeup_tag      = '0;
    bus.wakeup_value    = '0;
  endtask

  task automatic set_wake(input int idx, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    bus.wakeup_active[idx] = 1'b1;
    bus.wakeup_tag[idx]    = tag;
    bus.wakeup_value[idx]  = val;
  endtask

  task automatic clear_wake();
    bus.wakeup_active = '0;
    bus.wakeup_tag    = '0;
    bus.wakeup_value  = '0;
  endtask

  // Called just after a posedge; the alloc is taken at the following posedge.
  task automatic alloc(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                       input logic [TAG_W-1:0] rd, input logic [DATA_W-1:0] imm,
                       input logic [TAG_W-1:0] t1, input logic r1, input logic [DATA_W-1:0] v1,
                       input logic [TAG_W-1:0] t2, input logic r2, input logic [DATA_W-1:0] v2);
    if (!bus.alloc_ready) begin
      check("alloc_ready_pre", 128'(bus.alloc_ready), 128'd1);
      return;
    end
    bus.alloc_valid     = 1'b1;
    bus.alloc_op        = op;
    bus.alloc_rob_idx   = rob;
    bus.alloc_rd        = rd;
    bus.alloc_imm       = imm;
    bus.alloc_rs1_tag   = t1;
    bus.alloc_rs1_ready = r1;
    bus.alloc_rs1_value = v1;
    bus.alloc_rs2_tag   = t2;
    bus.alloc_rs2_ready = r2;
    bus.alloc_rs2_value = v2;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget, input string tag);
    int n = 0;
    while ((int'(bus.count) != target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(bus.count), 128'(target));
  endtask

  // Scoreboard: every accepted issue must match the front of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.issue_valid && bus.issue_ready) begin
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 128'(bus.issue_rob_idx), 128'h1_0000);
        end else begin
          check("issue_data",
                128'(pack(bus.issue_op, bus.issue_rob_idx, bus.issue_rd, bus.issue_imm,
                          bus.issue_rs1_value, bus.issue_rs2_value)),
                128'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm, v1, v2;

    idle_inputs();
    bus.issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_count",       128'(bus.count),       128'd0);
    check("rst_alloc_ready", 128'(bus.alloc_ready), 128'd1);
    check("rst_issue_valid", 128'(bus.issue_valid), 128'd0);
    check("rst_issue_rd",    128'(bus.issue_rd),    128'd0);
    check("rst_issue_rs1",   128'(bus.issue_rs1_value), 128'd0);

    // 1: both operands ready at alloc
    step();
    bus.issue_ready = 1'b1;
    exp_q.push_back(pack(8'h11, 6'd1, 6'd33, 32'd100, 32'd5, 32'd7));
    alloc(8'h11, 6'd1, 6'd33, 32'd100, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    @(negedge clk);
    check("t1_issue_valid", 128'(bus.issue_valid),     128'd1);
    check("t1_rs1",         128'(bus.issue_rs1_value), 128'd5);
    check("t1_rs2",         128'(bus.issue_rs2_value), 128'd7);
    check("t1_count",       128'(bus.count),           128'd1);
    step();
    @(negedge clk);
    check("t1_count_after", 128'(bus.count), 128'd0);

    // 2: rs1 waits for a later wakeup on bus 2
    step();
    exp_q.push_back(pack(8'h22, 6'd2, 6'd34, 32'd0, 32'hABCD, 32'd8));
    alloc(8'h22, 6'd2, 6'd34, 32'd0, 6'd40, 1'b0, 32'd0, 6'd3, 1'b1, 32'd8);
    @(negedge clk);
    check("t2_waiting", 128'(bus.issue_valid), 128'd0);
    step();
    set_wake(2, 6'd40, 32'hABCD);
    @(negedge clk);
    check("t2_wake_cycle", 128'(bus.issue_valid), 128'd0);
    step();
    clear_wake();
    @(negedge clk);
    check("t2_issue_valid", 128'(bus.issue_valid),     128'd1);
    check("t2_rs1",         128'(bus.issue_rs1_value), 128'hABCD);
    step();

    // 3: rs2 captured from a wakeup in the alloc cycle
    set_wake(0, 6'd41, 32'd9);
    exp_q.push_back(pack(8'h33, 6'd3, 6'd35, 32'd3, 32'd1, 32'd9));
    alloc(8'h33, 6'd3, 6'd35, 32'd3, 6'd4, 1'b1, 32'd1, 6'd41, 1'b0, 32'd0);
    clear_wake();
    @(negedge clk);
    check("t3_issue_valid", 128'(bus.issue_valid),     128'd1);
    check("t3_rs2",         128'(bus.issue_rs2_value), 128'd9);
    step();

    // 4: fill, one issue frees a slot, refill lands in slot 0 but must issue last
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      op  = OP_W'($urandom_range(0, 255));
      imm = $urandom_range(0, 32'h7fff_ffff);
      v1  = $urandom_range(0, 32'h7fff_ffff);
      v2  = $urandom_range(0, 32'h7fff_ffff);
      exp_q.push_back(pack(op, ROB_W'(i), TAG_W'(i + 1), imm, v1, v2));
      alloc(op, ROB_W'(i), TAG_W'(i + 1), imm, 6'd5, 1'b1, v1, 6'd6, 1'b1, v2);
    end
    @(negedge clk);
    check("t4_full_alloc_ready", 128'(bus.alloc_ready), 128'd0);
    check("t4_full_count",       128'(bus.count),       128'd16);
    step();
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
    @(negedge clk);
    check("t4_after_issue_alloc_ready", 128'(bus.alloc_ready), 128'd1);
    check("t4_after_issue_count",       128'(bus.count),       128'd15);
    step();
    exp_q.push_back(pack(8'h5A, 6'd20, 6'd50, 32'd20, 32'd21, 32'd22));
    alloc(8'h5A, 6'd20, 6'd50, 32'd20, 6'd7, 1'b1, 32'd21, 6'd8, 1'b1, 32'd22);
    @(negedge clk);
    check("t4_refill_count", 128'(bus.count), 128'd16);
    step();
    bus.issue_ready = 1'b1;
    wait_count(0, 40, "t4_drained");

    // 5: A waits on tag 50 while younger B and C issue first
    step();
    alloc(8'hA0, 6'd30, 6'd40, 32'd0, 6'd50, 1'b0, 32'd0, 6'd9, 1'b1, 32'd2);
    exp_q.push_back(pack(8'hB0, 6'd31, 6'd41, 32'd1, 32'd3, 32'd4));
    alloc(8'hB0, 6'd31, 6'd41, 32'd1, 6'd10, 1'b1, 32'd3, 6'd11, 1'b1, 32'd4);
    exp_q.push_back(pack(8'hC0, 6'd32, 6'd42, 32'd2, 32'd5, 32'd6));
    alloc(8'hC0, 6'd32, 6'd42, 32'd2, 6'd12, 1'b1, 32'd5, 6'd13, 1'b1, 32'd6);
    wait_count(1, 10, "t5_a_waiting");
    check("t5_a_blocked", 128'(bus.issue_valid), 128'd0);
    step();
    exp_q.push_back(pack(8'hA0, 6'd30, 6'd40, 32'd0, 32'h1234, 32'd2));
    set_wake(3, 6'd50, 32'h1234);
    step();
    clear_wake();
    wait_count(0, 5, "t5_a_issued");

    // Tag-0 broadcast must not wake an entry waiting on tag 0
    step();
    alloc(8'hD0, 6'd33, 6'd43, 32'd0, 6'd0, 1'b0, 32'd0, 6'd14, 1'b1, 32'd1);
    set_wake(1, 6'd0, 32'd77);
    step();
    clear_wake();
    @(negedge clk);
    check("t5_tag0_ignored", 128'(bus.issue_valid), 128'd0);
    check("t5_tag0_count",   128'(bus.count),       128'd1);

    // 6: reset with 5 entries held
    step();
    bus.issue_ready = 1'b0;
    alloc(8'hE0, 6'd34, 6'd44, 32'd0, 6'd60, 1'b0, 32'd0, 6'd15, 1'b1, 32'd1);
    for (int i = 0; i < 3; i++)
      alloc(8'hE1, ROB_W'(35 + i), 6'd45, 32'd0, 6'd16, 1'b1, 32'd1, 6'd17, 1'b1, 32'd2);
    @(negedge clk);
    check("t6_count_held", 128'(bus.count), 128'd5);
    step();
    set_wake(0, 6'd60, 32'd5);
    reset_n = 1'b0;
    #1;
    check("t6_rst_count",       128'(bus.count),       128'd0);
    check("t6_rst_issue_valid", 128'(bus.issue_valid), 128'd0);
    check("t6_rst_alloc_ready", 128'(bus.alloc_ready), 128'd1);
    step();
    step();
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    bus.issue_ready = 1'b1;
    @(negedge clk);
    check("t6_post_issue_valid", 128'(bus.issue_valid), 128'd0);
    step();
    clear_wake();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_stay_empty", 128'(bus.issue_valid | (bus.count != 0)), 128'd0);
    end
    step();
    exp_q.push_back(pack(8'hF0, 6'd40, 6'd46, 32'd9, 32'd10, 32'd11));
    alloc(8'hF0, 6'd40, 6'd46, 32'd9, 6'd18, 1'b1, 32'd10, 6'd19, 1'b1, 32'd11);
    @(negedge clk);
    check("t6_recover_issue_valid", 128'(bus.issue_valid), 128'd1);
    step();
    @(negedge clk);

    check("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
